// File: rtl/mem_slave_pkg.sv
// Shared encodings for the memory-slave verification model: burst types,
// response codes, read-engine FSM states and the per-beat byte count.
package mem_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 512;

    // Bytes carried by one beat of a DATA_WIDTH-bit bus.
    function automatic int unsigned beat_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rd_req_fifo.sv
// Synchronous request FIFO; dout is a combinational view of the head entry.
module rd_req_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 46
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB tells a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign dout  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/data_read_gen.sv
// AXI read-burst engine: queues AR requests, fetches beats from the model
// memory through a combinational port and presents registered R beats.
module data_read_gen
    import mem_slave_pkg::*;
#(
    parameter int unsigned ADD_ID_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADD_ID_WIDTH-1:0] arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [ADD_ID_WIDTH-1:0] rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned BEAT_BYTES = beat_bytes(DATA_WIDTH);
    localparam int unsigned SIZE_LOG2  = $clog2(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BEAT_BYTES);

    // Queued request; 'fixed' selects FIXED vs INCR addressing, since WRAP and
    // reserved bursts are already folded into 'err'.
    typedef struct packed {
        logic [ADD_ID_WIDTH-1:0] id;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [7:0]              len;
        logic                    fixed;
        logic                    err;
    } ar_req_t;

    localparam int unsigned REQ_W = $bits(ar_req_t);

    ar_req_t                 req_in;
    ar_req_t                 req_out;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    load;

    rd_state_e               state;
    logic [ADD_ID_WIDTH-1:0] id_q;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [7:0]              len_q;
    logic [7:0]              beat_cnt;
    logic                    fixed_q;
    logic                    err_q;

    assign arready   = !fifo_full;
    assign fifo_push = arvalid && !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign load      = rready || !rvalid;
    assign mem_addr  = (state == ST_BURST) ? cur_addr : '0;

    always_comb begin
        req_in       = '0;
        req_in.id    = arid;
        req_in.addr  = araddr;
        req_in.len   = arlen;
        req_in.fixed = (arburst == 2'(BURST_FIXED));
        req_in.err   = ((arburst != 2'(BURST_FIXED)) && (arburst != 2'(BURST_INCR))) ||
                       (arsize != 3'(SIZE_LOG2));
    end

    rd_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (REQ_W)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (req_in),
        .dout  (req_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Burst FSM with registered R-channel outputs; beats advance only on load edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            id_q     <= '0;
            cur_addr <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            fixed_q  <= 1'b0;
            err_q    <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= '0;
            rlast    <= 1'b0;
            rvalid   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                    end
                    if (!fifo_empty) begin
                        id_q     <= req_out.id;
                        cur_addr <= req_out.addr & ALIGN_MASK;
                        len_q    <= req_out.len;
                        fixed_q  <= req_out.fixed;
                        err_q    <= req_out.err;
                        beat_cnt <= '0;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (load) begin
                        rid      <= id_q;
                        rdata    <= err_q ? '0 : mem_rdata;
                        rresp    <= err_q ? 2'(RESP_SLVERR) : 2'(RESP_OKAY);
                        rlast    <= (beat_cnt == len_q);
                        rvalid   <= 1'b1;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (!fixed_q) cur_addr <= cur_addr + ADDR_STEP;
                        if (beat_cnt == len_q) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_read_gen.sv
// Scoreboard bench for data_read_gen: directed AR bursts, expected beats
// queued at issue time and checked by an independent R-channel monitor.
module tb_data_read_gen;

    logic         clk;
    logic         reset;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [31:0]  mem_addr;
    logic [511:0] mem_rdata;
    logic [3:0]   rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    typedef struct {
        logic [3:0]   id;
        logic [511:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    data_read_gen #(
        .ADD_ID_WIDTH (4),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (512),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: each word carries its own address so a wrong fetch shows up in rdata.
    function automatic logic [511:0] pat(input logic [31:0] a);
        return {16{a ^ 32'hC0DE_0000}};
    endfunction

    assign mem_rdata = pat(mem_addr);

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push_beat(input logic [3:0] id, input logic [31:0] addr,
                             input logic err, input logic last);
        beat_t b;
        b.id   = id;
        b.data = err ? 512'd0 : pat(addr);
        b.resp = err ? 2'b10 : 2'b00;
        b.last = last;
        exp_q.push_back(b);
    endtask

    // Call just after a rising edge; returns 1 time unit after the handshake edge.
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int waited = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!arready) timeout("arready wait");
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || rvalid) && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || rvalid) timeout(name);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a held beat must match the head; a consumed beat pops it.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset && rvalid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected beat: id %0d resp %0d last %0d", rid, rresp, rlast);
                end else begin
                    e = exp_q[0];
                    check("beat id/resp/last", 512'({rid, rresp, rlast}), 512'({e.id, e.resp, e.last}));
                    check("beat data", rdata, e.data);
                    if (rready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
        arsize = 3'd6; arburst = 2'b01; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset rvalid", 512'(rvalid), 512'(0));
        check("reset rlast", 512'(rlast), 512'(0));
        check("reset rid", 512'(rid), 512'(0));
        check("reset rdata", rdata, 512'(0));
        check("reset rresp", 512'(rresp), 512'(0));
        check("reset mem_addr", 512'(mem_addr), 512'(0));
        check("reset arready", 512'(arready), 512'(1));
        @(posedge clk); #1;

        // INCR 0x1000, four beats, with first-beat latency
        push_beat(4'd1, 32'h0000_1000, 1'b0, 1'b0);
        push_beat(4'd1, 32'h0000_1040, 1'b0, 1'b0);
        push_beat(4'd1, 32'h0000_1080, 1'b0, 1'b0);
        push_beat(4'd1, 32'h0000_10C0, 1'b0, 1'b1);
        send_ar(4'd1, 32'h0000_1000, 8'd3, 3'd6, 2'b01);
        @(negedge clk); check("latency after N", 512'(rvalid), 512'(0));
        @(negedge clk); check("latency after N+1", 512'(rvalid), 512'(0));
        @(negedge clk); check("latency after N+2", 512'(rvalid), 512'(1));
        @(posedge clk); #1;
        drain("incr drain");

        // FIXED from an unaligned address: every beat reads the aligned word 0x2000
        push_beat(4'd2, 32'h0000_2000, 1'b0, 1'b0);
        push_beat(4'd2, 32'h0000_2000, 1'b0, 1'b0);
        push_beat(4'd2, 32'h0000_2000, 1'b0, 1'b1);
        send_ar(4'd2, 32'h0000_2010, 8'd2, 3'd6, 2'b00);
        drain("fixed drain");

        // Error bursts: WRAP, wrong size, reserved burst type
        push_beat(4'd3, 32'h0, 1'b1, 1'b0);
        push_beat(4'd3, 32'h0, 1'b1, 1'b1);
        push_beat(4'd4, 32'h0, 1'b1, 1'b1);
        push_beat(4'd5, 32'h0, 1'b1, 1'b1);
        send_ar(4'd3, 32'h0000_3000, 8'd1, 3'd6, 2'b10);
        send_ar(4'd4, 32'h0000_3100, 8'd0, 3'd5, 2'b01);
        send_ar(4'd5, 32'h0000_3200, 8'd0, 3'd6, 2'b11);
        drain("error drain");

        // INCR across the top of the address space
        push_beat(4'd14, 32'hFFFF_FFC0, 1'b0, 1'b0);
        push_beat(4'd14, 32'h0000_0000, 1'b0, 1'b1);
        send_ar(4'd14, 32'hFFFF_FFC0, 8'd1, 3'd6, 2'b01);
        drain("addr wrap drain");

        // Five back-to-back ARs while stalled: one is popped into the burst
        // registers, the other four fill the queue.
        rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_beat(4'(6 + i), 32'h0000_4000 + 32'(i) * 32'h100, 1'b0, 1'b0);
            push_beat(4'(6 + i), 32'h0000_4040 + 32'(i) * 32'h100, 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++)
            send_ar(4'(6 + i), 32'h0000_4000 + 32'(i) * 32'h100, 8'd1, 3'd6, 2'b01);
        check("arready after fill", 512'(arready), 512'(0));
        repeat (3) @(posedge clk);
        #1 check("arready while stalled", 512'(arready), 512'(0));
        rready = 1'b1;
        begin
            int waited = 0;
            @(negedge clk);
            while (!arready && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            if (!arready) timeout("arready recovery");
        end
        @(posedge clk); #1;
        drain("five burst drain");

        // rready 1,0,0,1 mid-burst
        push_beat(4'd11, 32'h0000_5000, 1'b0, 1'b0);
        push_beat(4'd11, 32'h0000_5040, 1'b0, 1'b0);
        push_beat(4'd11, 32'h0000_5080, 1'b0, 1'b0);
        push_beat(4'd11, 32'h0000_50C0, 1'b0, 1'b1);
        send_ar(4'd11, 32'h0000_5000, 8'd3, 3'd6, 2'b01);
        begin
            int waited = 0;
            @(negedge clk);
            while (!rvalid && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            if (!rvalid) timeout("toggle first beat");
        end
        @(posedge clk); #1 rready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rready = 1'b1;
        drain("toggle drain");

        // Reset during beat 2 of an arlen=7 burst
        push_beat(4'd12, 32'h0000_6000, 1'b0, 1'b0);
        push_beat(4'd12, 32'h0000_6040, 1'b0, 1'b0);
        send_ar(4'd12, 32'h0000_6000, 8'd7, 3'd6, 2'b01);
        begin
            int waited = 0;
            @(negedge clk);
            while (!rvalid && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            if (!rvalid) timeout("reset-test first beat");
        end
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post-reset rvalid", 512'(rvalid), 512'(0));
        check("post-reset arready", 512'(arready), 512'(1));
        check("post-reset mem_addr", 512'(mem_addr), 512'(0));
        repeat (10) @(negedge clk);
        check("no beats after reset", 512'(rvalid), 512'(0));
        @(posedge clk); #1;

        // Single-beat burst after the abort
        push_beat(4'd13, 32'h0000_7000, 1'b0, 1'b1);
        send_ar(4'd13, 32'h0000_7000, 8'd0, 3'd6, 2'b01);
        drain("single beat drain");

        check("scoreboard empty", 512'(exp_q.size()), 512'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
